// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the parametrised SPI master.
//   spi_state_e : transfer state machine encoding
//   spi_mode_t  : SPI mode packed as {cpol, cpha}
//   SPI_MODE0-3 : the four standard SPI modes
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package spi_pkg;

  typedef enum logic [1:0] {
    SPI_IDLE  = 2'd0,
    SPI_SETUP = 2'd1,
    SPI_SHIFT = 2'd2,
    SPI_HOLD  = 2'd3
  } spi_state_e;

  typedef logic [1:0] spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = 2'b00;
  localparam spi_mode_t SPI_MODE1 = 2'b01;
  localparam spi_mode_t SPI_MODE2 = 2'b10;
  localparam spi_mode_t SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_if.sv
// -----------------------------------------------------------------------------
// spi_if
// Bundles the request/response handshake and the serial bus of the SPI master.
//   master modport : seen from the SPI master (requests in, serial bus out)
//   slave  modport : seen from the requester / attached slave side
// Optional macro SPI_MASTER_LSB_FIRST_EN adds the lsbFirst request signal.
// Parameters: DATA_W (word width), NUM_SLAVES (chip selects), SEL_W (select width).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface spi_if
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 3,
  parameter int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
);
  logic                  start;
  logic [SEL_W-1:0]      slaveSelect;
  logic                  cpol;
  logic                  cpha;
  logic [DATA_W-1:0]     masterDataToSend;
  logic                  MISO;
  logic [DATA_W-1:0]     masterDataReceived;
  logic                  busy;
  logic                  done;
  logic                  SCLK;
  logic [NUM_SLAVES-1:0] CS;
  logic                  MOSI;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic                  lsbFirst;

  modport master (
    input  start, slaveSelect, cpol, cpha, masterDataToSend, MISO, lsbFirst,
    output masterDataReceived, busy, done, SCLK, CS, MOSI
  );

  modport slave (
    output start, slaveSelect, cpol, cpha, masterDataToSend, MISO, lsbFirst,
    input  masterDataReceived, busy, done, SCLK, CS, MOSI
  );
`else
  modport master (
    input  start, slaveSelect, cpol, cpha, masterDataToSend, MISO,
    output masterDataReceived, busy, done, SCLK, CS, MOSI
  );

  modport slave (
    output start, slaveSelect, cpol, cpha, masterDataToSend, MISO,
    input  masterDataReceived, busy, done, SCLK, CS, MOSI
  );
`endif

endinterface

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
// SCLK divider for the SPI master. While enabled, it counts CLK_DIV system
// clocks per SCLK half-period and toggles SCLK at the end of each one. The
// leadEdge/trailEdge strobes are high during the single clk cycle whose
// closing rising edge produces the corresponding SCLK transition, so the
// master acts on exactly the same clk edge that moves SCLK.
// When disabled, SCLK is registered from idle_level and the counter clears.
// Ports:
//   clk, reset (async, active-low)
//   en         : count and toggle (high only while shifting)
//   idle_level : SCLK level to hold while disabled
//   leadEdge   : next clk edge produces a leading SCLK edge
//   trailEdge  : next clk edge produces a trailing SCLK edge
//   sclk       : registered serial clock level
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_clk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic idle_level,
  output logic leadEdge,
  output logic trailEdge,
  output logic sclk
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             phase_q, phase_d;   // 0: next edge is leading
  logic             sclk_q, sclk_d;
  logic             tick;

  always_comb begin
    tick      = en && (div_cnt_q == DIV_LAST);
    leadEdge  = tick && !phase_q;
    trailEdge = tick && phase_q;
    div_cnt_d = '0;
    phase_d   = 1'b0;
    sclk_d    = idle_level;
    if (en) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      phase_d   = phase_q ^ tick;
      sclk_d    = sclk_q ^ tick;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      phase_q   <= 1'b0;
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
      sclk_q    <= sclk_d;
    end
  end

  assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_param.sv
// -----------------------------------------------------------------------------
// spi_master_param
// Parametrised full-duplex SPI master: one DATA_W-bit word per transfer to the
// slave chosen by slaveSelect, any of the four CPOL/CPHA modes.
// Sequence: IDLE -> SETUP (CLK_DIV cycles) -> SHIFT (2*DATA_W SCLK edges)
//           -> HOLD (CLK_DIV cycles) -> IDLE, done pulsing on HOLD exit.
// Ports:
//   clk        : system clock
//   reset      : asynchronous, active-low
//   bus        : spi_if.master (start/slaveSelect/cpol/cpha/masterDataToSend/
//                MISO in; masterDataReceived/busy/done/SCLK/CS/MOSI out)
// Parameters: DATA_W (>=2), NUM_SLAVES (1..16), CLK_DIV (>=1), SEL_W.
// Optional macro SPI_MASTER_LSB_FIRST_EN: honours bus.lsbFirst (LSB-first
// transmit and assembly); otherwise transfers are always MSB first.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 3,
  parameter int CLK_DIV    = 2,
  parameter int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic clk,
  input  logic reset,
  spi_if.master bus
);

  localparam int               DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam int               CNT_W      = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] BITS_TOTAL = CNT_W'(DATA_W);
  localparam logic [SEL_W:0]   SEL_LIMIT  = (SEL_W + 1)'(NUM_SLAVES);

  // Control state (asynchronously reset)
  spi_state_e            state_q, state_d;
  logic [DIV_W-1:0]      cyc_cnt_q, cyc_cnt_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [NUM_SLAVES-1:0] cs_q, cs_d;
  logic                  mosi_q, mosi_d;
  logic [DATA_W-1:0]     rx_out_q, rx_out_d;

  // Per-transfer data, only meaningful outside IDLE
  spi_mode_t             mode_q, mode_d;
  logic                  lsb_q, lsb_d;
  logic [DATA_W-1:0]     tx_q, tx_d;
  logic [DATA_W-1:0]     rx_q, rx_d;

  logic                  lead_edge, trail_edge, sclk_w;
  logic                  clk_en, idle_level;
  logic                  sel_ok, lsb_live;
  logic                  sample_on_lead, sample_now, shift_now, last_edge;
  logic [CNT_W-1:0]      samples_after;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  // Drops the bit just presented on MOSI.
  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w,
                                                  input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  // Assembles received bits so the first bit lands where it was sent from.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                 input logic lsb,
                                                 input logic b);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  function automatic logic [NUM_SLAVES-1:0] cs_decode(input logic [SEL_W-1:0] sel);
    logic [NUM_SLAVES-1:0] cs;
    cs = '1;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == SEL_W'(i)) cs[i] = 1'b0;
    end
    return cs;
  endfunction

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign lsb_live = bus.lsbFirst;
`else
  assign lsb_live = 1'b0;
`endif

  assign sel_ok = ({1'b0, bus.slaveSelect} < SEL_LIMIT);
  assign clk_en = (state_q == SPI_SHIFT);
  // Idle SCLK tracks the live cpol between transfers and the latched one during.
  assign idle_level = (state_q == SPI_IDLE) ? bus.cpol : mode_q[1];

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk        (clk),
    .reset      (reset),
    .en         (clk_en),
    .idle_level (idle_level),
    .leadEdge   (lead_edge),
    .trailEdge  (trail_edge),
    .sclk       (sclk_w)
  );

  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    rx_out_d  = rx_out_q;
    mode_d    = mode_q;
    lsb_d     = lsb_q;
    tx_d      = tx_q;
    rx_d      = rx_q;

    sample_on_lead = (mode_q == SPI_MODE0) || (mode_q == SPI_MODE2);
    sample_now     = sample_on_lead ? lead_edge  : trail_edge;
    shift_now      = sample_on_lead ? trail_edge : lead_edge;
    samples_after  = bit_cnt_q + CNT_W'(sample_now);
    // The final trailing edge always follows (or carries) the last sample.
    last_edge      = trail_edge && (samples_after == BITS_TOTAL);

    case (state_q)
      SPI_IDLE: begin
        if (bus.start && sel_ok) begin
          state_d   = SPI_SETUP;
          cyc_cnt_d = '0;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          cs_d      = cs_decode(bus.slaveSelect);
          mode_d    = {bus.cpol, bus.cpha};
          lsb_d     = lsb_live;
          rx_d      = '0;
          if (!bus.cpha) begin
            // Leading-edge sampling needs the first bit valid before SCLK moves.
            mosi_d = first_bit(bus.masterDataToSend, lsb_live);
            tx_d   = shift_out(bus.masterDataToSend, lsb_live);
          end else begin
            tx_d   = bus.masterDataToSend;
          end
        end
      end

      SPI_SETUP: begin
        if (cyc_cnt_q == DIV_LAST) begin
          state_d   = SPI_SHIFT;
          cyc_cnt_d = '0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end

      SPI_SHIFT: begin
        if (sample_now) begin
          rx_d      = shift_in(rx_q, lsb_q, bus.MISO);
          bit_cnt_d = samples_after;
        end
        if (shift_now && !last_edge) begin
          mosi_d = first_bit(tx_q, lsb_q);
          tx_d   = shift_out(tx_q, lsb_q);
        end
        if (last_edge) begin
          state_d   = SPI_HOLD;
          cyc_cnt_d = '0;
        end
      end

      SPI_HOLD: begin
        if (cyc_cnt_q == DIV_LAST) begin
          state_d  = SPI_IDLE;
          cs_d     = '1;
          rx_out_d = rx_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end

      default: state_d = SPI_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SPI_IDLE;
      cyc_cnt_q <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_q      <= '1;
      mosi_q    <= 1'b0;
      rx_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      rx_out_q  <= rx_out_d;
    end
  end

  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    lsb_q  <= lsb_d;
    tx_q   <= tx_d;
    rx_q   <= rx_d;
  end

  assign bus.masterDataReceived = rx_out_q;
  assign bus.busy               = busy_q;
  assign bus.done               = done_q;
  assign bus.SCLK               = sclk_w;
  assign bus.CS                 = cs_q;
  assign bus.MOSI               = mosi_q;

endmodule

// File: tb/tb_spi_master_param.sv
// -----------------------------------------------------------------------------
// tb_spi_master_param
// Directed bench for spi_master_param (DATA_W=8, NUM_SLAVES=3, CLK_DIV=2).
// A behavioural slave shifts out a per-vector word and collects MOSI; the
// table of transfers covers all four modes, followed by back-to-back,
// out-of-range select and mid-transfer reset sequences. With
// SPI_MASTER_LSB_FIRST_EN a second 16-bit, CLK_DIV=1 instance runs an
// LSB-first echo loop.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master_param;
  import spi_pkg::*;

  localparam int DW       = 8;
  localparam int NS       = 3;
  localparam int CD       = 2;
  localparam int SW       = 2;
  localparam int BUSY_CYC = (2 * DW + 2) * CD;  // 36
  localparam int DONE_AT  = BUSY_CYC + 1;       // 37

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_if #(.DATA_W(DW), .NUM_SLAVES(NS), .SEL_W(SW)) bus ();

  spi_master_param #(
    .DATA_W     (DW),
    .NUM_SLAVES (NS),
    .CLK_DIV    (CD),
    .SEL_W      (SW)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef SPI_MASTER_LSB_FIRST_EN
  spi_if #(.DATA_W(16), .NUM_SLAVES(NS), .SEL_W(SW)) bus2 ();
  assign bus2.MISO = bus2.MOSI;

  spi_master_param #(
    .DATA_W     (16),
    .NUM_SLAVES (NS),
    .CLK_DIV    (1),
    .SEL_W      (SW)
  ) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );
`endif

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  logic [DW-1:0] slv_tx    = '0;
  logic          slv_cpol  = 1'b0;
  logic          slv_cpha  = 1'b0;
  logic [DW-1:0] slv_rx    = '0;
  int            slv_ptr   = 0;
  int            slv_samps = 0;
  logic          prev_sclk = 1'b0;
  logic [NS-1:0] prev_cs   = '1;

  always @(negedge clk) begin : slave_model
    logic sel, chg, is_lead, is_trail;
    sel      = (bus.CS != '1);
    chg      = (bus.SCLK !== prev_sclk);
    is_lead  = chg && (bus.SCLK !== slv_cpol);
    is_trail = chg && (bus.SCLK === slv_cpol);
    if (!sel) begin
      bus.MISO = 1'b0;
    end else if (prev_cs == '1) begin
      slv_ptr   = 0;
      slv_samps = 0;
      slv_rx    = '0;
      if (!slv_cpha) begin
        bus.MISO = slv_tx[DW-1];
        slv_ptr  = 1;
      end
    end else begin
      if ((is_lead && !slv_cpha) || (is_trail && slv_cpha)) begin
        slv_rx = {slv_rx[DW-2:0], bus.MOSI};
        slv_samps++;
      end
      if ((is_trail && !slv_cpha) || (is_lead && slv_cpha)) begin
        if (slv_ptr < DW) bus.MISO = slv_tx[DW-1-slv_ptr];
        slv_ptr++;
      end
    end
    prev_sclk = bus.SCLK;
    prev_cs   = bus.CS;
  end

  // ---------------- vector table ----------------
  typedef struct {
    spi_mode_t     mode;
    logic [SW-1:0] sel;
    logic [DW-1:0] tx;
    logic [DW-1:0] miso;
    logic [DW-1:0] exp_rx;
    logic [NS-1:0] exp_cs;
  } vec_t;

  vec_t vecs [4];

  task automatic run_vec(input vec_t v, input int idx);
    int            busy_cnt, done_cnt, done_at, cs_bad;
    logic [DW-1:0] rx_at;
    logic          busy_at_done;
    logic [NS-1:0] cs_at_done;
    @(negedge clk);
    bus.cpol             = v.mode[1];
    bus.cpha             = v.mode[0];
    bus.slaveSelect      = v.sel;
    bus.masterDataToSend = v.tx;
    slv_tx   = v.miso;
    slv_cpol = v.mode[1];
    slv_cpha = v.mode[0];
    @(negedge clk);
    @(negedge clk);
    check($sformatf("v%0d_idle_sclk", idx), 32'(bus.SCLK), 32'(v.mode[1]));
    bus.start = 1'b1;
    busy_cnt = 0; done_cnt = 0; done_at = 0; cs_bad = 0;
    rx_at = '0; busy_at_done = 1'b1; cs_at_done = '0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 1) begin
        bus.start = 1'b0;
        check($sformatf("v%0d_busy_k1", idx), 32'(bus.busy), 32'd1);
        check($sformatf("v%0d_cs_k1", idx), 32'(bus.CS), 32'(v.exp_cs));
      end
      if (n == 5) begin
        // Request inputs changing mid-transfer must be ignored.
        bus.masterDataToSend = ~v.tx;
        bus.slaveSelect      = v.sel ^ 2'b01;
        bus.cpha             = ~v.mode[0];
      end
      if (bus.busy) begin
        busy_cnt++;
        if (bus.CS !== v.exp_cs) cs_bad++;
      end
      if (bus.done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at      = n;
          rx_at        = bus.masterDataReceived;
          busy_at_done = bus.busy;
          cs_at_done   = bus.CS;
        end
      end
    end
    check($sformatf("v%0d_done_at", idx),      32'(done_at),      32'(DONE_AT));
    check($sformatf("v%0d_busy_cycles", idx),  32'(busy_cnt),     32'(BUSY_CYC));
    check($sformatf("v%0d_done_pulses", idx),  32'(done_cnt),     32'd1);
    check($sformatf("v%0d_cs_stable", idx),    32'(cs_bad),       32'd0);
    check($sformatf("v%0d_rx", idx),           32'(rx_at),        32'(v.exp_rx));
    check($sformatf("v%0d_mosi_word", idx),    32'(slv_rx),       32'(v.tx));
    check($sformatf("v%0d_slave_samps", idx),  32'(slv_samps),    32'(DW));
    check($sformatf("v%0d_busy_at_done", idx), 32'(busy_at_done), 32'd0);
    check($sformatf("v%0d_cs_at_done", idx),   32'(cs_at_done),   32'h7);
    check($sformatf("v%0d_sclk_after", idx),   32'(bus.SCLK),     32'(v.mode[1]));
  endtask

  initial begin
    int            done_cnt, first_done, second_done, gap, busy_seen, cs_bad;
    logic          released, started2;
    logic [DW-1:0] rx2;

    reset                = 1'b0;
    bus.start            = 1'b0;
    bus.slaveSelect      = '0;
    bus.cpol             = 1'b0;
    bus.cpha             = 1'b0;
    bus.masterDataToSend = '0;
`ifdef SPI_MASTER_LSB_FIRST_EN
    bus.lsbFirst          = 1'b0;
    bus2.start            = 1'b0;
    bus2.slaveSelect      = '0;
    bus2.cpol             = 1'b0;
    bus2.cpha             = 1'b0;
    bus2.masterDataToSend = '0;
    bus2.lsbFirst         = 1'b0;
`endif

    vecs[0] = '{SPI_MODE0, 2'd1, 8'hA5, 8'h3C, 8'h3C, 3'b101};
    vecs[1] = '{SPI_MODE1, 2'd0, 8'h81, 8'h7E, 8'h7E, 3'b110};
    vecs[2] = '{SPI_MODE2, 2'd2, 8'h81, 8'h7E, 8'h7E, 3'b011};
    vecs[3] = '{SPI_MODE3, 2'd1, 8'h81, 8'h7E, 8'h7E, 3'b101};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rx",   32'(bus.masterDataReceived), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sclk", 32'(bus.SCLK), 32'd0);
    check("rst_cs",   32'(bus.CS),   32'h7);
    check("rst_mosi", 32'(bus.MOSI), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Back-to-back: start held high across done
    @(negedge clk);
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.slaveSelect = 2'd0;
    bus.masterDataToSend = 8'h5A;
    slv_tx = 8'hC3; slv_cpol = 1'b0; slv_cpha = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    done_cnt = 0; first_done = 0; second_done = 0; gap = 0;
    released = 1'b0; started2 = 1'b0; rx2 = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        if (done_cnt == 1) first_done = n;
        if (done_cnt == 2) begin
          second_done = n;
          rx2 = bus.masterDataReceived;
        end
      end
      if (first_done != 0 && !started2) begin
        if (bus.busy) started2 = 1'b1;
        else if (bus.CS == '1) gap++;
      end
      if (done_cnt == 1 && bus.busy && !released) begin
        bus.start = 1'b0;
        released  = 1'b1;
      end
    end
    bus.start = 1'b0;
    check("b2b_done_pulses", 32'(done_cnt),    32'd2);
    check("b2b_first_done",  32'(first_done),  32'(DONE_AT));
    check("b2b_second_done", 32'(second_done), 32'(2 * DONE_AT));
    check("b2b_cs_gap_ok",   32'(gap >= 1),    32'd1);
    check("b2b_restarted",   32'(started2),    32'd1);
    check("b2b_rx2",         32'(rx2),         32'hC3);

    // Out-of-range slave select is ignored
    @(negedge clk);
    bus.slaveSelect = 2'd3;
    bus.start = 1'b1;
    busy_seen = 0; done_cnt = 0; cs_bad = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
      if (bus.done) done_cnt++;
      if (bus.CS !== 3'b111) cs_bad++;
    end
    bus.start = 1'b0;
    check("badsel_busy", 32'(busy_seen), 32'd0);
    check("badsel_done", 32'(done_cnt),  32'd0);
    check("badsel_cs",   32'(cs_bad),    32'd0);

    // Reset during bit 4 of a transfer
    @(negedge clk);
    bus.slaveSelect = 2'd2; bus.masterDataToSend = 8'h96;
    slv_tx = 8'h69;
    @(negedge clk);
    bus.start = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
    end
    check("midrst_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_rx",   32'(bus.masterDataReceived), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_sclk", 32'(bus.SCLK), 32'd0);
    check("midrst_cs",   32'(bus.CS),   32'h7);
    check("midrst_mosi", 32'(bus.MOSI), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    done_cnt = 0; busy_seen = 0;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
      if (bus.busy) busy_seen++;
    end
    check("midrst_no_done", 32'(done_cnt),  32'd0);
    check("midrst_idle",    32'(busy_seen), 32'd0);
    check("midrst_rx_kept", 32'(bus.masterDataReceived), 32'd0);

`ifdef SPI_MASTER_LSB_FIRST_EN
    // LSB-first echo loop, DATA_W=16, CLK_DIV=1
    begin
      int            d_at;
      logic [15:0]   rx16;
      @(negedge clk);
      bus2.slaveSelect = 2'd0; bus2.cpol = 1'b0; bus2.cpha = 1'b0;
      bus2.lsbFirst = 1'b1; bus2.masterDataToSend = 16'h0001;
      @(negedge clk);
      bus2.start = 1'b1;
      d_at = 0; rx16 = '0;
      for (int n = 1; n <= 45; n++) begin
        @(negedge clk);
        if (n == 1) begin
          bus2.start = 1'b0;
          check("lsb_first_mosi", 32'(bus2.MOSI), 32'd1);
        end
        if (bus2.done && d_at == 0) begin
          d_at = n;
          rx16 = bus2.masterDataReceived;
        end
      end
      check("lsb_done_at", 32'(d_at), 32'd35);
      check("lsb_echo_rx", 32'(rx16), 32'h0001);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master that replaces the fixed 8-bit, three-slave, mode-0-only master in the peripheral subsystem. It adds configurable word width, slave count and SCLK divider, all four CPOL/CPHA modes, and a clean start/busy/done handshake. All logic runs from one system clock. One transfer moves one word full-duplex to the slave addressed by `slaveSelect`.

## Interface
- `DATA_W`, default 8: bits per transfer, must be ≥ 2.
- `NUM_SLAVES`, default 3: number of chip-select lines, 1..16.
- `CLK_DIV`, default 2: `clk` cycles per SCLK half-period, must be ≥ 1.
- `SEL_W`, default $clog2(NUM_SLAVES) (minimum 1): width of `slaveSelect`.

Ports (clock and reset first):
- `clk` in 1: system clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled transfer request.
- `slaveSelect` in SEL_W: target slave index.
- `cpol` in 1: SCLK idle level.
- `cpha` in 1: 0 = sample on leading edge; 1 = sample on trailing edge.
- `masterDataToSend` in DATA_W: word to transmit.
- `MISO` in 1: serial data from the slave.
- `masterDataReceived` out DATA_W: last completed received word.
- `busy` out 1: a transfer is in progress.
- `done` out 1: one-cycle pulse marking transfer completion.
- `SCLK` out 1: serial clock.
- `CS` out NUM_SLAVES: active-low chip selects; bit i selects slave i.
- `MOSI` out 1: serial data to the slave.
- `lsbFirst` in 1: present only with `SPI_MASTER_LSB_FIRST_EN` defined.

## Operation

**State machine:** IDLE → SETUP → SHIFT → HOLD → IDLE.

**IDLE**
- `start`=1 with `slaveSelect` < NUM_SLAVES is accepted.
- On acceptance, latch `masterDataToSend`, `slaveSelect`, `cpol`, `cpha` (and `lsbFirst`), then go to SETUP.
- `start` with `slaveSelect` ≥ NUM_SLAVES is ignored: no CS asserted, no `done`.
- In IDLE, `SCLK` follows the live `cpol` input, registered.

**SETUP** (CLK_DIV cycles)
- The selected `CS` bit is driven low.
- With `cpha`=0, MOSI already presents the first bit.

**SHIFT** (2·DATA_W SCLK edges, one edge every CLK_DIV cycles)
- `cpha`=0: sample MISO into the shift register on leading edges; update MOSI on trailing edges, except after the final edge.
- `cpha`=1: update MOSI on leading edges; sample MISO on trailing edges.
- A bit counter of width $clog2(DATA_W)+1 counts samples. SHIFT exits after DATA_W samples and the final edge.

**HOLD** (CLK_DIV cycles)
- SCLK is at its idle level; CS stays low.
- On exit: CS goes all-high, `masterDataReceived` loads the shift register, `done`=1 for one cycle, `busy`=0.

**General rules**
- `start` is ignored while `busy`=1. Inputs that change mid-transfer have no effect.
- `start` held high across `done` begins the next transfer in the `done` cycle, with back-to-back CS deassertion of at least one cycle.
- Reset asserted mid-transfer aborts immediately. All outputs take their reset values; no `done` is produced.

**Reset values:** `masterDataReceived`=0, `busy`=0, `done`=0, `SCLK`=0, `CS`=all ones, `MOSI`=0.

## Timing
- `start` sampled at edge k: `busy`=1 and CS low from cycle k+1.
- `busy` stays high for (2·DATA_W+2)·CLK_DIV cycles.
- `done` pulses in cycle k+(2·DATA_W+2)·CLK_DIV+1, coincident with `busy`=0 and the new `masterDataReceived`.
- Defaults (8 bits, CLK_DIV 2): 36 busy cycles, `done` at k+37.
- SCLK frequency is f_clk / (2·CLK_DIV). MOSI changes only on its shift edge. MISO is sampled on the internal `clk` edge that generates the sampling SCLK edge.

## Configuration
- `SPI_MASTER_LSB_FIRST_EN` defined:
  - The `lsbFirst` port exists.
  - `lsbFirst`=1 transmits and assembles LSB first; `lsbFirst`=0 gives MSB first.
  - Received bit order always matches transmitted bit order.
- Not defined: no port; always MSB first.

## Structure
- Package `spi_pkg` holds:
  - the state enum (`SPI_IDLE`, `SPI_SETUP`, `SPI_SHIFT`, `SPI_HOLD`);
  - the mode constants `SPI_MODE0..3` as {cpol,cpha}.
- Sub-module `spi_clk_gen`:
  - divide counter producing single-cycle `leadEdge`/`trailEdge` strobes and the SCLK level;
  - enabled only in SHIFT.
- Top level holds the FSM, shift register, bit counter and CS decode.

## Test plan
- Mode 0, DATA_W=8, CLK_DIV=2, slaveSelect=1, send 0xA5, slave returns 0x3C:
  - MOSI bits 1,0,1,0,0,1,0,1; CS=3'b101 during transfer;
  - `masterDataReceived`=0x3C with `done` at k+37.
- Modes 1, 2, 3 with send 0x81, receive 0x7E: correct idle SCLK level, correct sample edges, received 0x7E in each mode.
- `start` held high: two consecutive transfers; CS high ≥1 cycle between them; exactly two `done` pulses.
- slaveSelect=3 with NUM_SLAVES=3: CS stays 3'b111, `busy` stays 0, no `done`.
- `reset` low during bit 4: all outputs at reset values in the same cycle; `masterDataReceived`=0; no `done`.
- `SPI_MASTER_LSB_FIRST_EN` with `lsbFirst`=1, send 0x01, DATA_W=16, CLK_DIV=1: first MOSI bit is 1; echo loop (MISO tied to MOSI) returns 0x0001.
